// File: rtl/spi_shared_pkg.sv
// Shared SPI front-end types and sizing constants.
// ADDR_SIZE mirrors the RAM address/data width so the wrapper and slave agree.
package spi_shared_pkg;

    localparam int unsigned ADDR_SIZE = 8;
    localparam int unsigned WORD_W    = ADDR_SIZE + 2;
    localparam int unsigned CNT_W     = $clog2(WORD_W);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises {cmd, payload} words from MOSI for the RAM and
// serialises the RAM's read byte back onto MISO, one bit per clk.
module spi_slave #(
    parameter int unsigned ADDR_SIZE = spi_shared_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    output logic                 MISO
);
    import spi_shared_pkg::*;

    localparam int unsigned RX_W     = ADDR_SIZE + 2;
    localparam int unsigned RX_CNT_W = $clog2(RX_W);
    localparam int unsigned TX_CNT_W = $clog2(ADDR_SIZE + 1);

    state_e                state_q, state_d;
    logic [RX_CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [RX_W-1:0]       rx_shift_q, rx_shift_d;
    logic [RX_W-1:0]       rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_done_q, rx_done_d;
    logic                  rd_addr_done_q, rd_addr_done_d;
    logic [ADDR_SIZE-2:0]  tx_shift_q, tx_shift_d;
    logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic                  tx_active_q, tx_active_d;
    logic                  tx_started_q, tx_started_d;
    logic                  miso_q, miso_d;

    logic [RX_W-1:0]       rx_next;

    assign rx_next  = {rx_shift_q[RX_W-2:0], MOSI};
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign MISO     = miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_done_q      <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_active_q    <= 1'b0;
            tx_started_q   <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_done_q      <= rx_done_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_active_q    <= tx_active_d;
            tx_started_q   <= tx_started_d;
            miso_q         <= miso_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_done_d      = rx_done_q;
        rd_addr_done_d = rd_addr_done_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_active_d    = tx_active_q;
        tx_started_d   = tx_started_q;
        miso_d         = 1'b0;

        if (SS_n) begin
            // Frame end or abort: drop any partial word and any shift-out in flight.
            state_d      = StIdle;
            rx_cnt_d     = '0;
            rx_shift_d   = '0;
            rx_done_d    = 1'b0;
            tx_shift_d   = '0;
            tx_cnt_d     = '0;
            tx_active_d  = 1'b0;
            tx_started_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StChkCmd;
                StChkCmd: begin
                    if (!MOSI)               state_d = StWrite;
                    else if (rd_addr_done_q) state_d = StReadData;
                    else                     state_d = StReadAdd;
                end
                StWrite, StReadAdd, StReadData: begin
                    if (!rx_done_q) begin
                        rx_shift_d = rx_next;
                        rx_cnt_d   = rx_cnt_q + RX_CNT_W'(1);
                        if (rx_cnt_q == RX_CNT_W'(RX_W - 1)) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            rx_done_d  = 1'b1;
                            if (state_q == StReadAdd)  rd_addr_done_d = 1'b1;
                            if (state_q == StReadData) rd_addr_done_d = 1'b0;
                        end
                    end else if (state_q == StReadData) begin
                        // One byte per read-data frame; tx_valid is ignored once loaded.
                        if (tx_active_q) begin
                            if (tx_cnt_q != '0) begin
                                miso_d     = tx_shift_q[ADDR_SIZE-2];
                                tx_shift_d = tx_shift_q << 1;
                                tx_cnt_d   = tx_cnt_q - TX_CNT_W'(1);
                            end else begin
                                tx_active_d = 1'b0;
                            end
                        end else if (!tx_started_q && tx_valid) begin
                            miso_d       = tx_data[ADDR_SIZE-1];
                            tx_shift_d   = tx_data[ADDR_SIZE-2:0];
                            tx_cnt_d     = TX_CNT_W'(ADDR_SIZE - 1);
                            tx_active_d  = 1'b1;
                            tx_started_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: command frames, read shift-out,
// abort, asynchronous reset mid-shift and spurious tx_valid.
module tb_spi_slave;
    import spi_shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       MISO;

    int checks   = 0;
    int failures = 0;

    spi_slave #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full frame (SS_n low, command bit, 10 data bits, 2 spare bits)
    // and reports what was observed; SS_n is left low.
    task automatic run_frame(input logic cmd, input logic [9:0] word, output int vcount,
                             output logic [9:0] vdata, output int vedge, output logic miso_any);
        vcount   = 0;
        vdata    = '0;
        vedge    = 0;
        miso_any = 1'b0;
        SS_n     = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 1)       MOSI = 1'b0;
            else if (e == 2)  MOSI = cmd;
            else if (e <= 12) MOSI = word[12-e];
            else              MOSI = 1'b1;
            tick();
            if (rx_valid) begin
                vcount++;
                vdata = rx_data;
                vedge = e;
            end
            miso_any = miso_any | MISO;
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        #3;
        checks++; if (rx_data !== 10'h000) begin failures++; $display("FAIL reset_rx_data got=%h exp=000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", MISO); end
        checks++; if (dut.state_q !== StIdle) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, StIdle); end
        checks++; if (dut.rd_addr_done_q !== 1'b0) begin failures++; $display("FAIL reset_rd_addr_done got=%b exp=0", dut.rd_addr_done_q); end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_addr();
        int n, e; logic [9:0] d; logic m;
        run_frame(1'b0, 10'h005, n, d, e, m);
        end_frame();
        checks++; if (n !== 1) begin failures++; $display("FAIL wr_addr_pulses got=%0d exp=1", n); end
        checks++; if (d !== 10'h005) begin failures++; $display("FAIL wr_addr_data got=%h exp=005", d); end
        checks++; if (e !== 12) begin failures++; $display("FAIL wr_addr_latency got=%0d exp=12", e); end
        checks++; if (dut.rd_addr_done_q !== 1'b0) begin failures++; $display("FAIL wr_addr_rd_done got=%b exp=0", dut.rd_addr_done_q); end
    endtask

    task automatic test_write_data();
        int n, e; logic [9:0] d; logic m;
        run_frame(1'b0, 10'h1AA, n, d, e, m);
        end_frame();
        checks++; if (n !== 1) begin failures++; $display("FAIL wr_data_pulses got=%0d exp=1", n); end
        checks++; if (d !== 10'h1AA) begin failures++; $display("FAIL wr_data_data got=%h exp=1aa", d); end
        checks++; if (m !== 1'b0) begin failures++; $display("FAIL wr_data_miso got=%b exp=0", m); end
    endtask

    task automatic test_read();
        int n, e; logic [9:0] d; logic m; logic [7:0] exp_byte;
        run_frame(1'b1, 10'h205, n, d, e, m);
        end_frame();
        checks++; if (d !== 10'h205 || n !== 1) begin failures++; $display("FAIL rd_addr_data got=%h/%0d exp=205/1", d, n); end
        checks++; if (dut.rd_addr_done_q !== 1'b1) begin failures++; $display("FAIL rd_addr_done_set got=%b exp=1", dut.rd_addr_done_q); end
        run_frame(1'b1, 10'h300, n, d, e, m);
        checks++; if (d !== 10'h300 || n !== 1 || e !== 12) begin
            failures++; $display("FAIL rd_data_word got=%h/%0d/%0d exp=300/1/12", d, n, e); end
        checks++; if (dut.rd_addr_done_q !== 1'b0) begin failures++; $display("FAIL rd_done_clear got=%b exp=0", dut.rd_addr_done_q); end
        tx_data = 8'hAA; tx_valid = 1'b1;
        tick();
        tx_data = 8'h55;  // held tx_valid during shift-out must be ignored
        exp_byte = 8'hAA;
        for (int i = 7; i >= 0; i--) begin
            checks++; if (MISO !== exp_byte[i]) begin failures++; $display("FAIL rd_miso_bit%0d got=%b exp=%b", i, MISO, exp_byte[i]); end
            if (i > 0) tick();
        end
        tick();
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL rd_miso_after got=%b exp=0", MISO); end
        tick(); tick();
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL rd_miso_no_reload got=%b exp=0", MISO); end
        tx_valid = 1'b0;
        end_frame();
        SS_n = 1'b0; tick();
        MOSI = 1'b1; tick();
        checks++; if (dut.state_q !== StReadAdd) begin failures++; $display("FAIL rd_third_state got=%0d exp=%0d", dut.state_q, StReadAdd); end
        end_frame();
    endtask

    task automatic test_abort();
        int n, e; logic [9:0] d; logic m; int pulses;
        pulses = 0;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0]; tick();
            if (rx_valid) pulses++;
        end
        end_frame();
        if (rx_valid) pulses++;
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
        checks++; if (dut.state_q !== StIdle) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, StIdle); end
        run_frame(1'b0, 10'h155, n, d, e, m);
        end_frame();
        checks++; if (d !== 10'h155 || n !== 1 || e !== 12) begin
            failures++; $display("FAIL abort_next_frame got=%h/%0d/%0d exp=155/1/12", d, n, e); end
    endtask

    task automatic test_reset_shiftout();
        int n, e; logic [9:0] d; logic m;
        run_frame(1'b1, 10'h2C0, n, d, e, m);
        end_frame();
        run_frame(1'b1, 10'h3C0, n, d, e, m);
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL rst_shift_pre got=%b exp=1", MISO); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL rst_shift_miso got=%b exp=0", MISO); end
        checks++; if (dut.state_q !== StIdle) begin failures++; $display("FAIL rst_shift_state got=%0d exp=%0d", dut.state_q, StIdle); end
        checks++; if (dut.rd_addr_done_q !== 1'b0) begin failures++; $display("FAIL rst_shift_rd_done got=%b exp=0", dut.rd_addr_done_q); end
        checks++; if (rx_data !== 10'h000) begin failures++; $display("FAIL rst_shift_rx_data got=%h exp=000", rx_data); end
        SS_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_spurious_tx_valid();
        int n, e; logic [9:0] d; logic m; logic idle_miso;
        idle_miso = 1'b0;
        tx_data = 8'hFF; tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_miso = idle_miso | MISO;
        end
        checks++; if (idle_miso !== 1'b0) begin failures++; $display("FAIL spur_idle_miso got=%b exp=0", idle_miso); end
        run_frame(1'b0, 10'h0F3, n, d, e, m);
        end_frame();
        checks++; if (m !== 1'b0) begin failures++; $display("FAIL spur_write_miso got=%b exp=0", m); end
        checks++; if (d !== 10'h0F3 || n !== 1) begin failures++; $display("FAIL spur_write_data got=%h/%0d exp=0f3/1", d, n); end
        tx_valid = 1'b0;
        run_frame(1'b1, 10'h211, n, d, e, m);
        end_frame();
        checks++; if (dut.rd_addr_done_q !== 1'b1 || d !== 10'h211) begin
            failures++; $display("FAIL spur_next_read got=%b/%h exp=1/211", dut.rd_addr_done_q, d); end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_reset_shiftout();
        test_spurious_tx_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
